// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the hazard controller: forwarding selects,
// multi-cycle FSM states and the stall/flush control bundle.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_BUSY,
    MD_DONE
  } md_state_t;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic flush_d;
    logic flush_e;
    logic flush_m;
  } hazard_ctrl_t;

  localparam hazard_ctrl_t HZ_NONE = '0;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic        en
  );
    return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Forwarding compare for one execute source operand.
// Ports: src, M/W dest + write flags in; sel (fwd_sel_t) out.
module fwd_unit
  import hazard_ctrl_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] src,
  input  logic [RA_W-1:0] write_reg_m,
  input  logic            reg_write_m,
  input  logic            mem_to_reg_m,
  input  logic [RA_W-1:0] write_reg_w,
  input  logic            reg_write_w,
  output fwd_sel_t        sel
);

  logic nz;
  logic hit_m;
  logic hit_w;

  assign nz = |src;

  // Load data is not available until W, so M only forwards ALU results.
  assign hit_m = reg_write_m && !mem_to_reg_m &&
                 (write_reg_m == src) && nz;
  assign hit_w = reg_write_w && (write_reg_w == src) && nz;

  always_comb begin
    sel = FWD_RF;
    if (hit_m)
      sel = FWD_M;
    else if (hit_w)
      sel = FWD_W;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: forwarding selects, load-use bubble, branch flush
// and mul/div busy FSM. Optional perf counters under HAZARD_PERF_EN.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MD_LAT = 32,
  parameter int RA_W   = 5
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [RA_W-1:0] rs_d,
  input  logic [RA_W-1:0] rt_d,
  input  logic [RA_W-1:0] rs_e,
  input  logic [RA_W-1:0] rt_e,
  input  logic [RA_W-1:0] write_reg_e,
  input  logic            reg_write_e,
  input  logic            mem_to_reg_e,
  input  logic            md_start_e,
  input  logic [RA_W-1:0] write_reg_m,
  input  logic            reg_write_m,
  input  logic            mem_to_reg_m,
  input  logic            branch_taken_m,
  input  logic [RA_W-1:0] write_reg_w,
  input  logic            reg_write_w,
  output logic [1:0]      forward_a,
  output logic [1:0]      forward_b,
  output logic            stall_f,
  output logic            stall_d,
  output logic            stall_e,
  output logic            flush_d,
  output logic            flush_e,
  output logic            flush_m,
  output logic            md_busy,
`ifdef HAZARD_PERF_EN
  output logic [31:0]     perf_stall_cycles,
  output logic [31:0]     perf_flush_count,
`endif
  output logic            md_done
);

  localparam int CNT_W = $clog2(MD_LAT);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MD_LAT - 2);

  fwd_sel_t     fwd_a;
  fwd_sel_t     fwd_b;
  md_state_t    state;
  md_state_t    state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic         lu;
  logic         busy;
  hazard_ctrl_t ctl;

  fwd_unit #(.RA_W(RA_W)) u_fwd_a (
    .src          (rs_e),
    .write_reg_m  (write_reg_m),
    .reg_write_m  (reg_write_m),
    .mem_to_reg_m (mem_to_reg_m),
    .write_reg_w  (write_reg_w),
    .reg_write_w  (reg_write_w),
    .sel          (fwd_a)
  );

  fwd_unit #(.RA_W(RA_W)) u_fwd_b (
    .src          (rt_e),
    .write_reg_m  (write_reg_m),
    .reg_write_m  (reg_write_m),
    .mem_to_reg_m (mem_to_reg_m),
    .write_reg_w  (write_reg_w),
    .reg_write_w  (reg_write_w),
    .sel          (fwd_b)
  );

  assign forward_a = fwd_a;
  assign forward_b = fwd_b;

  assign lu = mem_to_reg_e && reg_write_e && (|write_reg_e) &&
              ((write_reg_e == rs_d) || (write_reg_e == rt_d));

  assign busy = (state == MD_BUSY);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // A start killed by a taken branch is a wrong-path op: ignore it.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      MD_IDLE: begin
        if (md_start_e && !branch_taken_m) begin
          cnt_n   = CNT_INIT;
          state_n = (MD_LAT == 2) ? MD_DONE : MD_BUSY;
        end
      end
      MD_BUSY: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1))
          state_n = MD_DONE;
      end
      MD_DONE: begin
        state_n = MD_IDLE;
      end
      default: begin
        state_n = MD_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Busy freezes F/D/E outright, so a load-use bubble would corrupt
  // the held op; a taken branch outranks load-use since both die.
  always_comb begin
    ctl = HZ_NONE;
    if (busy) begin
      ctl.stall_f = 1'b1;
      ctl.stall_d = 1'b1;
      ctl.stall_e = 1'b1;
      ctl.flush_m = 1'b1;
    end else if (branch_taken_m) begin
      ctl.flush_d = 1'b1;
      ctl.flush_e = 1'b1;
    end else if (lu) begin
      ctl.stall_f = 1'b1;
      ctl.stall_d = 1'b1;
      ctl.flush_e = 1'b1;
    end
  end

  assign stall_f = ctl.stall_f;
  assign stall_d = ctl.stall_d;
  assign stall_e = ctl.stall_e;
  assign flush_d = ctl.flush_d;
  assign flush_e = ctl.flush_e;
  assign flush_m = ctl.flush_m;
  assign md_busy = busy;
  assign md_done = (state == MD_DONE);

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      perf_stall_cycles <= '0;
      perf_flush_count  <= '0;
    end else begin
      perf_stall_cycles <= sat_inc(perf_stall_cycles, ctl.stall_f);
      perf_flush_count  <= sat_inc(perf_flush_count, branch_taken_m);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (MD_LAT=4 and MD_LAT=32 copies).
// Expected output vectors go through a scoreboard queue per cycle.
module tb_hazard_ctrl;

  localparam logic [7:0] NO  = 8'b0000_0000;
  localparam logic [7:0] LU  = 8'b1100_1000;
  localparam logic [7:0] BR  = 8'b0001_1000;
  localparam logic [7:0] BSY = 8'b1110_0110;
  localparam logic [7:0] DN  = 8'b0000_0001;

  typedef struct packed {
    logic [4:0] rs_d;
    logic [4:0] rt_d;
    logic [4:0] wre;
    logic       rwe;
    logic       mre;
    logic       mse;
    logic       bt;
    logic [7:0] ex;
  } stim_t;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wm;
    logic       rwm;
    logic       mm;
    logic [4:0] ww;
    logic       rww;
    logic [1:0] fa;
    logic [1:0] fb;
  } fwd_vec_t;

  logic clk = 1'b0;
  logic resetn;
  logic [4:0] rs_d, rt_d, rs_e, rt_e;
  logic [4:0] write_reg_e, write_reg_m, write_reg_w;
  logic reg_write_e, mem_to_reg_e, md_start_e;
  logic reg_write_m, mem_to_reg_m, branch_taken_m, reg_write_w;

  logic [1:0] fa4, fb4, fa32, fb32;
  logic sf4, sd4, se4, fd4, fe4, fm4, bz4, dn4;
  logic sf32, sd32, se32, fd32, fe32, fm32, bz32, dn32;
`ifdef HAZARD_PERF_EN
  logic [31:0] ps4, pf4, ps32, pf32;
`endif

  logic [11:0] obs4, obs32;
  logic [11:0] exp_q[$];
  logic [11:0] want;
  int checks = 0;
  int errors = 0;

  assign obs4  = {fa4, fb4, sf4, sd4, se4, fd4, fe4, fm4, bz4, dn4};
  assign obs32 = {fa32, fb32, sf32, sd32, se32, fd32, fe32, fm32,
                  bz32, dn32};

  always #5 clk = ~clk;

  hazard_ctrl #(.MD_LAT(4), .RA_W(5)) u_dut4 (
    .clk(clk), .resetn(resetn),
    .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .write_reg_e(write_reg_e), .reg_write_e(reg_write_e),
    .mem_to_reg_e(mem_to_reg_e), .md_start_e(md_start_e),
    .write_reg_m(write_reg_m), .reg_write_m(reg_write_m),
    .mem_to_reg_m(mem_to_reg_m), .branch_taken_m(branch_taken_m),
    .write_reg_w(write_reg_w), .reg_write_w(reg_write_w),
    .forward_a(fa4), .forward_b(fb4),
    .stall_f(sf4), .stall_d(sd4), .stall_e(se4),
    .flush_d(fd4), .flush_e(fe4), .flush_m(fm4),
    .md_busy(bz4),
`ifdef HAZARD_PERF_EN
    .perf_stall_cycles(ps4), .perf_flush_count(pf4),
`endif
    .md_done(dn4)
  );

  hazard_ctrl #(.MD_LAT(32), .RA_W(5)) u_dut32 (
    .clk(clk), .resetn(resetn),
    .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .write_reg_e(write_reg_e), .reg_write_e(reg_write_e),
    .mem_to_reg_e(mem_to_reg_e), .md_start_e(md_start_e),
    .write_reg_m(write_reg_m), .reg_write_m(reg_write_m),
    .mem_to_reg_m(mem_to_reg_m), .branch_taken_m(branch_taken_m),
    .write_reg_w(write_reg_w), .reg_write_w(reg_write_w),
    .forward_a(fa32), .forward_b(fb32),
    .stall_f(sf32), .stall_d(sd32), .stall_e(se32),
    .flush_d(fd32), .flush_e(fe32), .flush_m(fm32),
    .md_busy(bz32),
`ifdef HAZARD_PERF_EN
    .perf_stall_cycles(ps32), .perf_flush_count(pf32),
`endif
    .md_done(dn32)
  );

  task automatic clr_inputs();
    rs_d = '0; rt_d = '0; rs_e = '0; rt_e = '0;
    write_reg_e = '0; write_reg_m = '0; write_reg_w = '0;
    reg_write_e = 0; mem_to_reg_e = 0; md_start_e = 0;
    reg_write_m = 0; mem_to_reg_m = 0; branch_taken_m = 0;
    reg_write_w = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    clr_inputs();
    resetn = 0;
    @(posedge clk); #1;
    resetn = 1;
  endtask

  task automatic drive(input stim_t s);
    rs_d = s.rs_d; rt_d = s.rt_d; write_reg_e = s.wre;
    reg_write_e = s.rwe; mem_to_reg_e = s.mre;
    md_start_e = s.mse; branch_taken_m = s.bt;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    clr_inputs();
    resetn = 0;
    exp_q.push_back(12'h000);
    exp_q.push_back(12'h000);
    @(posedge clk); #1;
    resetn = 1;
    @(negedge clk);
    want = exp_q.pop_front();
    checks++;
    if (obs4 !== want) begin
      errors++;
      $display("FAIL reset4: got %b want %b", obs4, want);
    end
    want = exp_q.pop_front();
    checks++;
    if (obs32 !== want) begin
      errors++;
      $display("FAIL reset32: got %b want %b", obs32, want);
    end
  endtask

  task automatic test_forwarding();
    fwd_vec_t t [7];
    t = '{
      '{5'd3,  5'd4,  5'd3,  1'b1, 1'b0, 5'd4, 1'b1, 2'b10, 2'b01},
      '{5'd3,  5'd3,  5'd3,  1'b1, 1'b0, 5'd3, 1'b1, 2'b10, 2'b10},
      '{5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 5'd0, 1'b1, 2'b00, 2'b00},
      '{5'd3,  5'd7,  5'd3,  1'b1, 1'b1, 5'd3, 1'b1, 2'b01, 2'b00},
      '{5'd3,  5'd4,  5'd3,  1'b0, 1'b0, 5'd4, 1'b0, 2'b00, 2'b00},
      '{5'd31, 5'd31, 5'd31, 1'b1, 1'b0, 5'd5, 1'b1, 2'b10, 2'b10},
      '{5'd6,  5'd9,  5'd8,  1'b1, 1'b0, 5'd9, 1'b1, 2'b00, 2'b01}
    };
    do_reset();
    foreach (t[i]) begin
      @(posedge clk); #1;
      rs_e = t[i].rs; rt_e = t[i].rt;
      write_reg_m = t[i].wm; reg_write_m = t[i].rwm;
      mem_to_reg_m = t[i].mm;
      write_reg_w = t[i].ww; reg_write_w = t[i].rww;
      exp_q.push_back({t[i].fa, t[i].fb, NO});
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (obs4 !== want) begin
        errors++;
        $display("FAIL fwd[%0d]: got %b want %b", i, obs4, want);
      end
    end
    clr_inputs();
  endtask

  task automatic test_load_use();
    stim_t t [7];
    t = '{
      '{5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, LU},
      '{5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NO},
      '{5'd0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, LU},
      '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NO},
      '{5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, NO},
      '{5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, NO},
      '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, NO}
    };
    do_reset();
    foreach (t[i]) begin
      @(posedge clk); #1;
      drive(t[i]);
      exp_q.push_back({4'b0, t[i].ex});
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (obs4 !== want) begin
        errors++;
        $display("FAIL load_use[%0d]: got %b want %b", i, obs4, want);
      end
    end
    clr_inputs();
  endtask

  task automatic test_branch();
    stim_t t [4];
    t = '{
      '{5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, BR},
      '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, BR},
      '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NO},
      '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NO}
    };
    do_reset();
    foreach (t[i]) begin
      @(posedge clk); #1;
      drive(t[i]);
      exp_q.push_back({4'b0, t[i].ex});
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (obs4 !== want) begin
        errors++;
        $display("FAIL branch[%0d]: got %b want %b", i, obs4, want);
      end
    end
    clr_inputs();
  endtask

  task automatic test_multicycle();
    stim_t t [5];
    t = '{
      '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, NO},
      '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, BSY},
      '{5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, BSY},
      '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, DN},
      '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NO}
    };
    do_reset();
    foreach (t[i]) begin
      @(posedge clk); #1;
      drive(t[i]);
      exp_q.push_back({4'b0, t[i].ex});
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (obs4 !== want) begin
        errors++;
        $display("FAIL md4[%0d]: got %b want %b", i, obs4, want);
      end
    end
    clr_inputs();
  endtask

  task automatic test_back_to_back();
    stim_t t [9];
    t = '{
      '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, NO},
      '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, BSY},
      '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, BSY},
      '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, DN},
      '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, NO},
      '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, BSY},
      '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, BSY},
      '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, DN},
      '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NO}
    };
    do_reset();
    foreach (t[i]) begin
      @(posedge clk); #1;
      drive(t[i]);
      exp_q.push_back({4'b0, t[i].ex});
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (obs4 !== want) begin
        errors++;
        $display("FAIL b2b[%0d]: got %b want %b", i, obs4, want);
      end
    end
    clr_inputs();
  endtask

  task automatic test_reset_mid_busy();
    logic [7:0] ex;
    do_reset();
    for (int c = 0; c < 37; c++) begin
      @(posedge clk); #1;
      resetn = (c != 2);
      md_start_e = (c != 3) && (c != 36);
      if (c == 1 || c == 2 || (c >= 5 && c <= 34))
        ex = BSY;
      else if (c == 35)
        ex = DN;
      else
        ex = NO;
      exp_q.push_back({4'b0, ex});
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (obs32 !== want) begin
        errors++;
        $display("FAIL md32_rst[%0d]: got %b want %b", c, obs32, want);
      end
    end
    clr_inputs();
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    stim_t t [15];
    t = '{
      '{5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, LU},
      '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NO},
      '{5'd0, 5'd6, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, LU},
      '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NO},
      '{5'd7, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, LU},
      '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NO},
      '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, NO},
      '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, BSY},
      '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, BSY},
      '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, DN},
      '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NO},
      '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, BR},
      '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NO},
      '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, BR},
      '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NO}
    };
    do_reset();
    foreach (t[i]) begin
      @(posedge clk); #1;
      drive(t[i]);
      exp_q.push_back({4'b0, t[i].ex});
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (obs4 !== want) begin
        errors++;
        $display("FAIL perf_seq[%0d]: got %b want %b", i, obs4, want);
      end
    end
    checks++;
    if (ps4 !== 32'd5) begin
      errors++;
      $display("FAIL perf_stall: got %0d want 5", ps4);
    end
    checks++;
    if (pf4 !== 32'd2) begin
      errors++;
      $display("FAIL perf_flush: got %0d want 2", pf4);
    end
    clr_inputs();
  endtask
`endif

  initial begin
    clr_inputs();
    resetn = 0;
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_multicycle();
    test_back_to_back();
    test_reset_mid_busy();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
